inv_key_expansion: RTL and testbench

INV_KEY_EXPANSION -- requirements
Module: inv_key_expansion

---
 rtl/inv_key_expansion_if.sv | 22 ++
 rtl/inv_key_expansion.sv | 193 +++++++++++++++++++
 tb/tb_inv_key_expansion.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/inv_key_expansion_if.sv
// Round-key stream interface for inv_key_expansion.
// master: key source / round-key consumer; slave: the expander.
interface inv_key_expansion_if;
  logic         key_load;
  logic [0:127] key;
  logic         rk_ready;
  logic         busy;
  logic         rk_valid;
  logic [0:127] round_key;
  logic [3:0]   round_num;
  logic         rk_last;

  modport master (
    output key_load, key, rk_ready,
    input  busy, rk_valid, round_key, round_num, rk_last
  );

  modport slave (
    input  key_load, key, rk_ready,
    output busy, rk_valid, round_key, round_num, rk_last
  );
endinterface

// File: rtl/inv_key_expansion.sv
// AES-128 inverse key expansion: expands forward to round 10, then streams
// round keys 10 down to 0 under a valid/ready handshake.
// Optional macro INV_KEY_CACHE_EN: keep all 11 round keys in a register array
// and serve from it instead of recomputing each key on the fly.
module inv_key_expansion (
  input  logic                 clk,
  input  logic                 rst_n,
  inv_key_expansion_if.slave   bus
);

  localparam int unsigned KEY_W    = 128;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned RND_W    = 4;
  localparam int unsigned LAST_RND = 10;

  typedef enum logic [1:0] {IDLE, EXPAND, SERVE} state_t;

  // AES S-box, byte x lives at bits [8x +: 8] (bit 0 = MSB of entry 0)
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{x, 3'b000} +: 8];
  endfunction

  // SubWord(RotWord(w))
  function automatic logic [WORD_W-1:0] sub_rot(input logic [WORD_W-1:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  // Rcon for round r (1..10) placed in the top byte of a word
  function automatic logic [WORD_W-1:0] rcon_word(input logic [RND_W-1:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

  // Round r-1 key -> round r key
  function automatic logic [KEY_W-1:0] fwd_step(input logic [KEY_W-1:0] k,
                                                input logic [RND_W-1:0] r);
    logic [WORD_W-1:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot(k[31:0]) ^ rcon_word(r);
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Round r key -> round r-1 key
  function automatic logic [KEY_W-1:0] inv_step(input logic [KEY_W-1:0] k,
                                                input logic [RND_W-1:0] r);
    logic [WORD_W-1:0] c0, c1, c2, c3, p0, p1, p2, p3;
    c0 = k[127:96];
    c1 = k[95:64];
    c2 = k[63:32];
    c3 = k[31:0];
    p3 = c3 ^ c2;
    p2 = c2 ^ c1;
    p1 = c1 ^ c0;
    p0 = c0 ^ sub_rot(p3) ^ rcon_word(r);
    return {p0, p1, p2, p3};
  endfunction

  state_t             state;
  logic [RND_W-1:0]   cnt;
  logic [KEY_W-1:0]   kreg;
  logic               busy_q;
  logic               rk_valid_q;
  logic               rk_last_q;
  logic [KEY_W-1:0]   round_key_q;
  logic [RND_W-1:0]   round_num_q;

  logic [KEY_W-1:0]   fwd_key_c;
  logic [KEY_W-1:0]   prev_key_c;

  assign fwd_key_c = fwd_step(kreg, RND_W'(cnt + 4'd1));

`ifdef INV_KEY_CACHE_EN
  logic [KEY_W-1:0] cache [LAST_RND+1];
  logic [RND_W-1:0] prev_idx_c;

  assign prev_idx_c = (round_num_q == 4'd0) ? 4'd0 : RND_W'(round_num_q - 4'd1);
  assign prev_key_c = cache[prev_idx_c];

  // Record every round key as the forward expansion produces it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= int'(LAST_RND); i++) cache[i] <= '0;
    end else if (bus.key_load) begin
      cache[0] <= bus.key;
    end else if (state == EXPAND && cnt != RND_W'(LAST_RND)) begin
      cache[RND_W'(cnt + 4'd1)] <= fwd_key_c;
    end
  end
`else
  assign prev_key_c = inv_step(kreg, round_num_q);
`endif

  // Control FSM, key register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      kreg        <= '0;
      busy_q      <= 1'b0;
      rk_valid_q  <= 1'b0;
      rk_last_q   <= 1'b0;
      round_key_q <= '0;
      round_num_q <= '0;
    end else if (bus.key_load) begin
      state       <= EXPAND;
      cnt         <= '0;
      kreg        <= bus.key;
      busy_q      <= 1'b1;
      rk_valid_q  <= 1'b0;
      rk_last_q   <= 1'b0;
      round_key_q <= '0;
      round_num_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy_q     <= 1'b0;
          rk_valid_q <= 1'b0;
        end
        EXPAND: begin
          if (cnt == RND_W'(LAST_RND)) begin
            state       <= SERVE;
            busy_q      <= 1'b0;
            rk_valid_q  <= 1'b1;
            rk_last_q   <= 1'b0;
            round_key_q <= kreg;
            round_num_q <= RND_W'(LAST_RND);
          end else begin
            kreg <= fwd_key_c;
            cnt  <= RND_W'(cnt + 4'd1);
          end
        end
        SERVE: begin
          if (bus.rk_ready) begin
            if (round_num_q == 4'd0) begin
              state       <= IDLE;
              rk_valid_q  <= 1'b0;
              rk_last_q   <= 1'b0;
              round_key_q <= '0;
              round_num_q <= '0;
            end else begin
              kreg        <= prev_key_c;
              round_key_q <= prev_key_c;
              round_num_q <= RND_W'(round_num_q - 4'd1);
              rk_last_q   <= (round_num_q == 4'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.rk_valid  = rk_valid_q;
  assign bus.rk_last   = rk_last_q;
  assign bus.round_key = round_key_q;
  assign bus.round_num = round_num_q;

endmodule

// File: tb/tb_inv_key_expansion.sv
// Directed bench for inv_key_expansion using FIPS-197 key schedule vectors.
module tb_inv_key_expansion;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [127:0] exp_rk [11];
  logic [127:0] k_fips;
  logic [127:0] zero_r10;

  inv_key_expansion_if bus ();

  inv_key_expansion dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.key_load = 1'b1;
    bus.key = k_fips;
    bus.rk_ready = 1'b1;
    tick();
    tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.rk_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.rk_valid); end
    total++; if (bus.rk_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", bus.rk_last); end
    total++; if (bus.round_num !== 4'd0) begin bad++; $display("FAIL reset_num: got %0d want 0", bus.round_num); end
    total++; if (bus.round_key !== 128'h0) begin bad++; $display("FAIL reset_key: got %h want 0", bus.round_key); end
    bus.key_load = 1'b0;
    rst_n = 1'b1;
    tick();
    total++; if (bus.busy !== 1'b0 || bus.rk_valid !== 1'b0) begin bad++; $display("FAIL reset_release_idle: got busy=%b valid=%b want 0 0", bus.busy, bus.rk_valid); end
  endtask

  // Load, check exact latency, then stream all keys with rk_ready held high
  task automatic test_stream();
    bus.rk_ready = 1'b1;
    bus.key = k_fips;
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL stream_busy: got %b want 1", bus.busy); end
    for (int i = 1; i <= 10; i++) begin
      tick();
      total++; if (bus.rk_valid !== 1'b0 || bus.round_key !== 128'h0) begin bad++; $display("FAIL stream_early_valid: cycle %0d got valid=%b key=%h want 0", i, bus.rk_valid, bus.round_key); end
    end
    tick();
    total++; if (bus.rk_valid !== 1'b1) begin bad++; $display("FAIL stream_latency: got valid=%b want 1", bus.rk_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL stream_busy_done: got %b want 0", bus.busy); end
    total++; if (bus.round_num !== 4'd10 || bus.round_key !== exp_rk[10]) begin bad++; $display("FAIL stream_r10: got %0d %h want 10 %h", bus.round_num, bus.round_key, exp_rk[10]); end
    total++; if (bus.rk_last !== 1'b0) begin bad++; $display("FAIL stream_last_r10: got %b want 0", bus.rk_last); end
    for (int r = 9; r >= 0; r--) begin
      tick();
      total++; if (bus.rk_valid !== 1'b1 || bus.round_num !== 4'(r) || bus.round_key !== exp_rk[r]) begin bad++; $display("FAIL stream_round: got valid=%b num=%0d key=%h want 1 %0d %h", bus.rk_valid, bus.round_num, bus.round_key, r, exp_rk[r]); end
      total++; if (bus.rk_last !== (r == 0)) begin bad++; $display("FAIL stream_last: round %0d got %b want %b", r, bus.rk_last, (r == 0)); end
    end
    tick();
    total++; if (bus.rk_valid !== 1'b0 || bus.rk_last !== 1'b0 || bus.round_key !== 128'h0) begin bad++; $display("FAIL stream_end: got valid=%b last=%b key=%h want 0 0 0", bus.rk_valid, bus.rk_last, bus.round_key); end
    bus.rk_ready = 1'b0;
  endtask

  // rk_ready alternating: each key must hold through its stall cycle
  task automatic test_stall();
    bit seen;
    bus.rk_ready = 1'b0;
    bus.key = k_fips;
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (bus.rk_valid === 1'b1) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL stall_timeout: got no rk_valid want rk_valid within 20 cycles"); end
    for (int r = 10; r >= 0; r--) begin
      total++; if (bus.round_num !== 4'(r) || bus.round_key !== exp_rk[r]) begin bad++; $display("FAIL stall_round: got %0d %h want %0d %h", bus.round_num, bus.round_key, r, exp_rk[r]); end
      bus.rk_ready = 1'b0;
      tick();
      total++; if (bus.rk_valid !== 1'b1 || bus.round_num !== 4'(r) || bus.round_key !== exp_rk[r]) begin bad++; $display("FAIL stall_hold: got valid=%b num=%0d key=%h want 1 %0d %h", bus.rk_valid, bus.round_num, bus.round_key, r, exp_rk[r]); end
      bus.rk_ready = 1'b1;
      tick();
    end
    total++; if (bus.rk_valid !== 1'b0) begin bad++; $display("FAIL stall_end: got valid=%b want 0", bus.rk_valid); end
    bus.rk_ready = 1'b0;
  endtask

  // New all-zero key loaded while round 5 is being served
  task automatic test_reload();
    bus.rk_ready = 1'b1;
    bus.key = k_fips;
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    total++; if (bus.rk_valid !== 1'b1 || bus.round_num !== 4'd5 || bus.round_key !== exp_rk[5]) begin bad++; $display("FAIL reload_r5: got valid=%b num=%0d key=%h want 1 5 %h", bus.rk_valid, bus.round_num, bus.round_key, exp_rk[5]); end
    bus.key = 128'h0;
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
    total++; if (bus.rk_valid !== 1'b0 || bus.round_key !== 128'h0 || bus.busy !== 1'b1) begin bad++; $display("FAIL reload_restart: got valid=%b key=%h busy=%b want 0 0 1", bus.rk_valid, bus.round_key, bus.busy); end
    for (int i = 0; i < 10; i++) tick();
    total++; if (bus.rk_valid !== 1'b0) begin bad++; $display("FAIL reload_early: got valid=%b want 0", bus.rk_valid); end
    tick();
    total++; if (bus.rk_valid !== 1'b1 || bus.round_num !== 4'd10 || bus.round_key !== zero_r10) begin bad++; $display("FAIL reload_r10: got valid=%b num=%0d key=%h want 1 10 %h", bus.rk_valid, bus.round_num, bus.round_key, zero_r10); end
    bus.key_load = 1'b1;
    bus.key = k_fips;
    tick();
    bus.key_load = 1'b0;
    bus.rk_ready = 1'b0;
  endtask

  // key_load coinciding with the round-0 accept restarts without an IDLE cycle
  task automatic test_load_at_last();
    bus.rk_ready = 1'b1;
    bus.key = k_fips;
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
    for (int i = 0; i < 21; i++) tick();
    total++; if (bus.rk_valid !== 1'b1 || bus.round_num !== 4'd0 || bus.rk_last !== 1'b1 || bus.round_key !== exp_rk[0]) begin bad++; $display("FAIL last_r0: got valid=%b num=%0d last=%b key=%h want 1 0 1 %h", bus.rk_valid, bus.round_num, bus.rk_last, bus.round_key, exp_rk[0]); end
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
    total++; if (bus.rk_valid !== 1'b0 || bus.busy !== 1'b1 || bus.rk_last !== 1'b0) begin bad++; $display("FAIL last_restart: got valid=%b busy=%b last=%b want 0 1 0", bus.rk_valid, bus.busy, bus.rk_last); end
    for (int i = 0; i < 11; i++) tick();
    total++; if (bus.rk_valid !== 1'b1 || bus.round_num !== 4'd10 || bus.round_key !== exp_rk[10]) begin bad++; $display("FAIL last_r10: got valid=%b num=%0d key=%h want 1 10 %h", bus.rk_valid, bus.round_num, bus.round_key, exp_rk[10]); end
    bus.rk_ready = 1'b0;
  endtask

  // Reset pulse in EXPAND cycle 4, then load on the first released edge
  task automatic test_reset_mid();
    bit stray;
    bus.rk_ready = 1'b1;
    bus.key = k_fips;
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (bus.busy !== 1'b0 || bus.rk_valid !== 1'b0 || bus.rk_last !== 1'b0 || bus.round_num !== 4'd0 || bus.round_key !== 128'h0) begin bad++; $display("FAIL midrst_outputs: got busy=%b valid=%b last=%b num=%0d key=%h want all 0", bus.busy, bus.rk_valid, bus.rk_last, bus.round_num, bus.round_key); end
    stray = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.rk_valid !== 1'b0 || bus.busy !== 1'b0 || bus.round_key !== 128'h0) stray = 1'b1;
    end
    total++; if (stray) begin bad++; $display("FAIL midrst_stray: got activity after reset want idle"); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL first_load_busy: got %b want 1", bus.busy); end
    for (int i = 0; i < 11; i++) tick();
    total++; if (bus.rk_valid !== 1'b1 || bus.round_num !== 4'd10 || bus.round_key !== exp_rk[10]) begin bad++; $display("FAIL first_load_r10: got valid=%b num=%0d key=%h want 1 10 %h", bus.rk_valid, bus.round_num, bus.round_key, exp_rk[10]); end
    bus.rk_ready = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    k_fips    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    zero_r10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    exp_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    rst_n = 1'b0;
    bus.key_load = 1'b0;
    bus.key = '0;
    bus.rk_ready = 1'b0;
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_reload();
    test_load_at_last();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
